// File: rtl/progmem_arb_pkg.sv
// Shared types and defaults for the program-RAM Avalon arbiter.
// Holds the owner encoding and the hold counter helpers.
package progmem_arb_pkg;

  localparam int DEF_ADDR_W   = 15;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MAX_HOLD = 4;
  localparam int HOLD_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  function automatic logic [HOLD_CNT_W-1:0] hold_inc(
    input logic [HOLD_CNT_W-1:0] c
  );
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/progmem_arb_perf.sv
// Per-master accept and stall counters for the program-RAM arbiter.
// Only instantiated when PROGMEM_ARB_PERF_EN is defined.
module progmem_arb_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_acc0,
  input  logic        i_acc1,
  input  logic        i_stall0,
  input  logic        i_stall1,
  output logic [31:0] o_acc0,
  output logic [31:0] o_acc1,
  output logic [31:0] o_stall0,
  output logic [31:0] o_stall1
);

  logic [31:0] r_acc0;
  logic [31:0] r_acc1;
  logic [31:0] r_stall0;
  logic [31:0] r_stall1;

  // Clear takes priority over any increment in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc0   <= '0;
      r_acc1   <= '0;
      r_stall0 <= '0;
      r_stall1 <= '0;
    end else if (i_clear) begin
      r_acc0   <= '0;
      r_acc1   <= '0;
      r_stall0 <= '0;
      r_stall1 <= '0;
    end else begin
      if (i_acc0)   r_acc0   <= r_acc0 + 32'd1;
      if (i_acc1)   r_acc1   <= r_acc1 + 32'd1;
      if (i_stall0) r_stall0 <= r_stall0 + 32'd1;
      if (i_stall1) r_stall1 <= r_stall1 + 32'd1;
    end
  end

  assign o_acc0   = r_acc0;
  assign o_acc1   = r_acc1;
  assign o_stall0 = r_stall0;
  assign o_stall1 = r_stall1;

endmodule

// File: rtl/progmem_avalon_arbiter.sv
// Two-master bounded round-robin arbiter in front of the program RAM.
// Define PROGMEM_ARB_PERF_EN to add the perf counter ports.
module progmem_avalon_arbiter
  import progmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
`ifdef PROGMEM_ARB_PERF_EN
  input  logic                  perf_clear,
  output logic [31:0]           perf_acc0,
  output logic [31:0]           perf_acc1,
  output logic [31:0]           perf_stall0,
  output logic [31:0]           perf_stall1,
`endif
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam logic [HOLD_CNT_W-1:0] LP_MAX_HOLD =
    HOLD_CNT_W'(MAX_HOLD);

  owner_e                r_owner;
  owner_e                w_owner_nxt;
  owner_e                w_own_sel;
  logic [HOLD_CNT_W-1:0] r_hold_cnt;
  logic [HOLD_CNT_W-1:0] w_hold_nxt;
  logic                  r_last_served;
  logic                  w_last_nxt;
  logic                  r_rd_pend;
  logic                  r_rd_owner;

  logic w_req0;
  logic w_req1;
  logic w_hold_ok;
  logic w_sel;
  logic w_gnt0;
  logic w_gnt1;
  logic w_acc0;
  logic w_acc1;
  logic w_acc;
  logic w_sel_rd;
  logic w_sel_wr;
  logic w_acc_rd;
  logic w_wait0;
  logic w_wait1;

  assign w_req0    = m0_read | m0_write;
  assign w_req1    = m1_read | m1_write;
  assign w_hold_ok = r_hold_cnt < LP_MAX_HOLD;

  // w_sel picks the master that may use the RAM this cycle.
  always_comb begin
    w_sel = ~r_last_served;
    if (w_req0 && !w_req1) begin
      w_sel = 1'b0;
    end else if (w_req1 && !w_req0) begin
      w_sel = 1'b1;
    end else if (r_owner == OWN0) begin
      w_sel = ~w_hold_ok;
    end else if (r_owner == OWN1) begin
      w_sel = w_hold_ok;
    end
  end

  assign w_gnt0 = w_req0 & ~w_sel;
  assign w_gnt1 = w_req1 & w_sel;
  assign w_acc0 = w_gnt0 & ~reset;
  assign w_acc1 = w_gnt1 & ~reset;
  assign w_acc  = w_acc0 | w_acc1;

  assign w_sel_rd = w_sel ? m1_read  : m0_read;
  assign w_sel_wr = w_sel ? m1_write : m0_write;
  assign w_acc_rd = w_acc & w_sel_rd & ~w_sel_wr;

  assign w_wait0 = reset | (w_req0 & ~w_gnt0);
  assign w_wait1 = reset | (w_req1 & ~w_gnt1);

  assign m0_waitrequest = w_wait0;
  assign m1_waitrequest = w_wait1;

  assign mem_address    = w_sel ? m1_address : m0_address;
  assign mem_byteenable = w_sel ? m1_byteenable
                                : m0_byteenable;
  assign mem_writedata  = w_sel ? m1_writedata
                                : m0_writedata;
  assign mem_chipselect = w_acc;
  assign mem_write      = w_acc & w_sel_wr;
  assign mem_clken      = 1'b1;

  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = r_rd_pend & ~r_rd_owner;
  assign m1_readdatavalid = r_rd_pend & r_rd_owner;

  assign w_own_sel = w_sel ? OWN1 : OWN0;

  always_comb begin
    w_owner_nxt = r_owner;
    w_hold_nxt  = r_hold_cnt;
    w_last_nxt  = r_last_served;
    if (w_acc) begin
      if (r_owner == w_own_sel) begin
        w_hold_nxt = hold_inc(r_hold_cnt);
      end else begin
        w_owner_nxt = w_own_sel;
        w_hold_nxt  = HOLD_CNT_W'(1);
      end
      w_last_nxt = w_sel;
    end else if (!w_req0 && !w_req1) begin
      w_owner_nxt = IDLE;
      w_hold_nxt  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner       <= IDLE;
      r_hold_cnt    <= '0;
      r_last_served <= 1'b1;
      r_rd_pend     <= 1'b0;
      r_rd_owner    <= 1'b0;
    end else begin
      r_owner       <= w_owner_nxt;
      r_hold_cnt    <= w_hold_nxt;
      r_last_served <= w_last_nxt;
      r_rd_pend     <= w_acc_rd;
      if (w_acc_rd) r_rd_owner <= w_sel;
    end
  end

  a_m0_rw_excl: assert property (
    @(posedge clk) disable iff (reset)
    !(m0_read && m0_write));

  a_m1_rw_excl: assert property (
    @(posedge clk) disable iff (reset)
    !(m1_read && m1_write));

`ifdef PROGMEM_ARB_PERF_EN
  progmem_arb_perf u_perf (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (perf_clear),
    .i_acc0   (w_acc0),
    .i_acc1   (w_acc1),
    .i_stall0 (w_wait0),
    .i_stall1 (w_wait1),
    .o_acc0   (perf_acc0),
    .o_acc1   (perf_acc1),
    .o_stall0 (perf_stall0),
    .o_stall1 (perf_stall1)
  );
`endif

endmodule

// File: tb/tb_progmem_avalon_arbiter.sv
// Self-checking bench for progmem_avalon_arbiter with a RAM model
// and a transaction-level arbitration reference.
module tb_progmem_avalon_arbiter;

  localparam int MH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [14:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;
`ifdef PROGMEM_ARB_PERF_EN
  logic        perf_clear;
  logic [31:0] perf_acc0, perf_acc1, perf_stall0, perf_stall1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  progmem_avalon_arbiter #(
    .ADDR_W(15), .DATA_W(32), .MAX_HOLD(MH)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read),
    .m0_write(m0_write), .m0_byteenable(m0_byteenable),
    .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read),
    .m1_write(m1_write), .m1_byteenable(m1_byteenable),
    .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
`ifdef PROGMEM_ARB_PERF_EN
    .perf_clear(perf_clear),
    .perf_acc0(perf_acc0), .perf_acc1(perf_acc1),
    .perf_stall0(perf_stall0), .perf_stall1(perf_stall1),
`endif
    .mem_address(mem_address),
    .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect),
    .mem_write(mem_write),
    .mem_writedata(mem_writedata),
    .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  // ---------------- RAM model (1-cycle read latency) --------------
  logic [31:0] ram   [0:32767];
  bit          wflag [0:32767];
  logic [31:0] rdq;

  function automatic logic [31:0] init_word(input logic [14:0] a);
    return {a, 2'b01, a} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ram_word(input logic [14:0] a);
    return wflag[a] ? ram[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        ram[mem_address] <= merge(ram_word(mem_address),
                                  mem_writedata, mem_byteenable);
        wflag[mem_address] <= 1'b1;
      end else begin
        rdq <= ram_word(mem_address);
      end
    end
  end
  assign mem_readdata = rdq;

  // ---------------- reference model --------------------------------
  logic [31:0] refmem [int];
  int          m_cur, m_streak, m_last;
  bit          m_pend;
  int          m_pend_own;
  logic [31:0] m_pend_data;
  int unsigned cnt_acc [2];
  int unsigned cnt_stall [2];
  int          e_sel;

  function automatic logic [31:0] refval(input logic [14:0] a);
    return refmem.exists(int'(a)) ? refmem[int'(a)] : init_word(a);
  endfunction

  function automatic void model_reset();
    m_cur = -1; m_streak = 0; m_last = 1; m_pend = 0;
    cnt_acc[0] = 0; cnt_acc[1] = 0;
    cnt_stall[0] = 0; cnt_stall[1] = 0;
  endfunction

  // Which master may go this cycle (-1 = nobody asks).
  function automatic int pick(input bit q0, input bit q1);
    if (!q0 && !q1) return -1;
    if (q0 && !q1) return 0;
    if (q1 && !q0) return 1;
    if (m_cur < 0) return 1 - m_last;
    if (m_streak < MH) return m_cur;
    return 1 - m_cur;
  endfunction

  task automatic drive(input bit r0, input bit w0,
                       input logic [14:0] a0, input logic [31:0] d0,
                       input logic [3:0] be0,
                       input bit r1, input bit w1,
                       input logic [14:0] a1, input logic [31:0] d1,
                       input logic [3:0] be1);
    @(negedge clk);
    m0_read = r0; m0_write = w0; m0_address = a0;
    m0_writedata = d0; m0_byteenable = be0;
    m1_read = r1; m1_write = w1; m1_address = a1;
    m1_writedata = d1; m1_byteenable = be1;
    #1;
    e_sel = pick(r0 | w0, r1 | w1);
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
  endtask

  task automatic commit();
    bit q0, q1, wr;
    logic [14:0] a;
    @(posedge clk);
    q0 = m0_read | m0_write;
    q1 = m1_read | m1_write;
    m_pend = 0;
    if (e_sel >= 0) begin
      wr = e_sel ? m1_write : m0_write;
      a  = e_sel ? m1_address : m0_address;
      if (wr)
        refmem[int'(a)] = merge(refval(a),
          e_sel ? m1_writedata : m0_writedata,
          e_sel ? m1_byteenable : m0_byteenable);
      else begin
        m_pend = 1; m_pend_own = e_sel; m_pend_data = refval(a);
      end
      if (e_sel == m_cur) m_streak = (m_streak < 15) ? m_streak + 1 : 15;
      else begin m_cur = e_sel; m_streak = 1; end
      m_last = e_sel;
      cnt_acc[e_sel]++;
    end else begin
      m_cur = -1; m_streak = 0;
    end
    if (q0 && e_sel != 0) cnt_stall[0]++;
    if (q1 && e_sel != 1) cnt_stall[1]++;
`ifdef PROGMEM_ARB_PERF_EN
    if (perf_clear) begin
      cnt_acc[0] = 0; cnt_acc[1] = 0;
      cnt_stall[0] = 0; cnt_stall[1] = 0;
    end
`endif
  endtask

  task automatic rst_on();
    @(negedge clk);
    reset = 1'b1;
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    model_reset();
    e_sel = -1;
    #1;
  endtask

  task automatic rst_off();
    @(negedge clk);
    reset = 1'b0;
    e_sel = -1;
    commit();
  endtask

  // ---------------- scenarios --------------------------------------
  task automatic test_reset();
    @(negedge clk);
    m0_read = 1; m1_read = 1;
    #1;
    checks++;
    if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin
      errors++;
      $display("FAIL reset_wait: got %b%b want 11",
               m0_waitrequest, m1_waitrequest);
    end
    checks++;
    if ({mem_chipselect, mem_write, m0_readdatavalid,
         m1_readdatavalid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outs: cs=%b wr=%b v0=%b v1=%b want 0",
               mem_chipselect, mem_write,
               m0_readdatavalid, m1_readdatavalid);
    end
    rst_on();
    rst_off();
    idle();
    checks++;
    if ({m0_waitrequest, m1_waitrequest, mem_chipselect,
         m0_readdatavalid, m1_readdatavalid} !== 5'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got %b want 00000",
               {m0_waitrequest, m1_waitrequest, mem_chipselect,
                m0_readdatavalid, m1_readdatavalid});
    end
    commit();
  endtask

  task automatic test_single_read();
    drive(0, 1, 15'h0010, 32'hDEADBEEF, 4'hF, 0, 0, '0, '0, '0);
    checks++;
    if (m0_waitrequest !== 1'b0 || mem_write !== 1'b1) begin
      errors++;
      $display("FAIL sr_write: wait=%b wr=%b want 0/1",
               m0_waitrequest, mem_write);
    end
    commit();
    drive(1, 0, 15'h0010, '0, '0, 0, 0, '0, '0, '0);
    checks++;
    if (m0_waitrequest !== 1'b0 || mem_address !== 15'h0010) begin
      errors++;
      $display("FAIL sr_read: wait=%b addr=%h want 0/0010",
               m0_waitrequest, mem_address);
    end
    commit();
    idle();
    checks++;
    if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0 ||
        m0_readdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sr_data: v0=%b v1=%b data=%h want 1/0/deadbeef",
               m0_readdatavalid, m1_readdatavalid, m0_readdata);
    end
    commit();
  endtask

  task automatic test_contention();
    int ex, pv;
    rst_on();
    rst_off();
    for (int i = 0; i < 13; i++) begin
      if (i < 12) begin
        drive(1, 0, 15'(i), '0, '0, 1, 0, 15'(16'h100 + i), '0, '0);
        ex = (i / MH) % 2;
        checks++;
        if (m0_waitrequest !== (ex == 1) ||
            m1_waitrequest !== (ex == 0)) begin
          errors++;
          $display("FAIL cont_grant %0d: wait=%b%b want owner m%0d",
                   i, m0_waitrequest, m1_waitrequest, ex);
        end
      end else begin
        idle();
      end
      if (i > 0) begin
        pv = ((i - 1) / MH) % 2;
        checks++;
        if (m0_readdatavalid !== (pv == 0) ||
            m1_readdatavalid !== (pv == 1) ||
            m0_readdata !== m_pend_data) begin
          errors++;
          $display("FAIL cont_rdv %0d: v=%b%b d=%h want m%0d d=%h",
                   i, m0_readdatavalid, m1_readdatavalid,
                   m0_readdata, pv, m_pend_data);
        end
      end
      commit();
    end
  endtask

  task automatic test_write_be();
    logic [31:0] old;
    old = refval(15'h7FFF);
    drive(0, 0, '0, '0, '0, 0, 1, 15'h7FFF, 32'hA5A5A5A5, 4'b0011);
    checks++;
    if (m1_waitrequest !== 1'b0 || mem_write !== 1'b1 ||
        mem_byteenable !== 4'b0011 || mem_address !== 15'h7FFF) begin
      errors++;
      $display("FAIL wb_write: wait=%b wr=%b be=%b a=%h",
               m1_waitrequest, mem_write, mem_byteenable, mem_address);
    end
    commit();
    drive(0, 0, '0, '0, '0, 1, 0, 15'h7FFF, '0, '0);
    commit();
    idle();
    checks++;
    if (m1_readdatavalid !== 1'b1 || m0_readdatavalid !== 1'b0 ||
        m1_readdata !== {old[31:16], 16'hA5A5}) begin
      errors++;
      $display("FAIL wb_read: v1=%b v0=%b d=%h want 1/0/%h",
               m1_readdatavalid, m0_readdatavalid, m1_readdata,
               {old[31:16], 16'hA5A5});
    end
    commit();
  endtask

  task automatic test_alternating();
    drive(1, 0, 15'h0021, '0, '0, 0, 0, '0, '0, '0);
    checks++;
    if (m0_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL alt_w0: got %b want 0", m0_waitrequest);
    end
    commit();
    drive(0, 0, '0, '0, '0, 1, 0, 15'h0042, '0, '0);
    checks++;
    if (m1_waitrequest !== 1'b0 || m0_readdatavalid !== 1'b1 ||
        m1_readdatavalid !== 1'b0 ||
        m0_readdata !== refval(15'h0021)) begin
      errors++;
      $display("FAIL alt_n1: w1=%b v=%b%b d=%h", m1_waitrequest,
               m0_readdatavalid, m1_readdatavalid, m0_readdata);
    end
    commit();
    idle();
    checks++;
    if (m1_readdatavalid !== 1'b1 || m0_readdatavalid !== 1'b0 ||
        m1_readdata !== refval(15'h0042)) begin
      errors++;
      $display("FAIL alt_n2: v=%b%b d=%h want 01/%h",
               m0_readdatavalid, m1_readdatavalid, m1_readdata,
               refval(15'h0042));
    end
    commit();
  endtask

  task automatic test_reset_midread();
    drive(0, 0, '0, '0, '0, 1, 0, 15'h0055, '0, '0);
    checks++;
    if (m1_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL rm_acc: got %b want 0", m1_waitrequest);
    end
    commit();
    rst_on();
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
      errors++;
      $display("FAIL rm_drop: v=%b%b want 00",
               m0_readdatavalid, m1_readdatavalid);
    end
    rst_off();
    idle();
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid,
         m0_waitrequest, m1_waitrequest} !== 4'b0000) begin
      errors++;
      $display("FAIL rm_idle: got %b want 0000",
               {m0_readdatavalid, m1_readdatavalid,
                m0_waitrequest, m1_waitrequest});
    end
    commit();
    drive(1, 0, 15'h0003, '0, '0, 1, 0, 15'h0004, '0, '0);
    checks++;
    if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL rm_tie: wait=%b%b want 01",
               m0_waitrequest, m1_waitrequest);
    end
    commit();
    idle();
    commit();
  endtask

  task automatic test_random();
    int k0, k1;
    logic [14:0] a0, a1;
    bit q0, q1;
    for (int i = 0; i < 600; i++) begin
      k0 = $urandom_range(0, 3);
      k1 = $urandom_range(0, 3);
      a0 = ($urandom_range(0, 7) == 0) ? 15'($urandom)
                                       : 15'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 7) == 0) ? 15'($urandom)
                                       : 15'($urandom_range(0, 15));
      drive(k0 == 1 || k0 == 3, k0 == 2, a0, $urandom, 4'($urandom),
            k1 == 1 || k1 == 3, k1 == 2, a1, $urandom, 4'($urandom));
      q0 = k0 != 0;
      q1 = k1 != 0;
      checks++;
      if (m0_waitrequest !== (q0 && e_sel != 0) ||
          m1_waitrequest !== (q1 && e_sel != 1)) begin
        errors++;
        $display("FAIL rnd_wait %0d: got %b%b want %b%b", i,
                 m0_waitrequest, m1_waitrequest,
                 q0 && e_sel != 0, q1 && e_sel != 1);
      end
      checks++;
      if (mem_chipselect !== (e_sel >= 0)) begin
        errors++;
        $display("FAIL rnd_cs %0d: got %b want %b", i,
                 mem_chipselect, e_sel >= 0);
      end
      if (e_sel >= 0) begin
        checks++;
        if (mem_address !== (e_sel ? a1 : a0) ||
            mem_write !== (e_sel ? (k1 == 2) : (k0 == 2))) begin
          errors++;
          $display("FAIL rnd_mem %0d: a=%h wr=%b sel=m%0d", i,
                   mem_address, mem_write, e_sel);
        end
      end
      checks++;
      if (m0_readdatavalid !== (m_pend && m_pend_own == 0) ||
          m1_readdatavalid !== (m_pend && m_pend_own == 1)) begin
        errors++;
        $display("FAIL rnd_rdv %0d: got %b%b want %b%b", i,
                 m0_readdatavalid, m1_readdatavalid,
                 m_pend && m_pend_own == 0, m_pend && m_pend_own == 1);
      end
      if (m_pend) begin
        checks++;
        if ((m_pend_own ? m1_readdata : m0_readdata) !== m_pend_data) begin
          errors++;
          $display("FAIL rnd_data %0d: got %h want %h", i,
                   m_pend_own ? m1_readdata : m0_readdata, m_pend_data);
        end
      end
      commit();
    end
    idle();
    commit();
  endtask

`ifdef PROGMEM_ARB_PERF_EN
  task automatic test_perf();
    rst_on();
    rst_off();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 15'(i), '0, '0, 1, 0, 15'(i + 32), '0, '0);
      commit();
    end
    idle();
    checks++;
    if (perf_acc0 !== 32'(cnt_acc[0]) ||
        perf_acc1 !== 32'(cnt_acc[1]) ||
        perf_acc0 + perf_acc1 !== 32'd10) begin
      errors++;
      $display("FAIL perf_acc: got %0d/%0d want %0d/%0d",
               perf_acc0, perf_acc1, cnt_acc[0], cnt_acc[1]);
    end
    checks++;
    if (perf_stall0 !== 32'(cnt_stall[0]) ||
        perf_stall1 !== 32'(cnt_stall[1]) ||
        perf_stall0 + perf_stall1 !== 32'd10) begin
      errors++;
      $display("FAIL perf_stall: got %0d/%0d want %0d/%0d",
               perf_stall0, perf_stall1, cnt_stall[0], cnt_stall[1]);
    end
    commit();
    perf_clear = 1'b1;
    drive(1, 0, 15'h1, '0, '0, 1, 0, 15'h2, '0, '0);
    commit();
    perf_clear = 1'b0;
    idle();
    checks++;
    if ({perf_acc0, perf_acc1, perf_stall0, perf_stall1} !== 128'd0) begin
      errors++;
      $display("FAIL perf_clear: got %0d %0d %0d %0d want 0",
               perf_acc0, perf_acc1, perf_stall0, perf_stall1);
    end
    commit();
  endtask
`endif

  initial begin
    reset = 1'b1;
    m0_read = 0; m0_write = 0; m0_address = '0;
    m0_byteenable = '0; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0;
    m1_byteenable = '0; m1_writedata = '0;
`ifdef PROGMEM_ARB_PERF_EN
    perf_clear = 1'b0;
`endif
    model_reset();
    e_sel = -1;
    repeat (3) @(negedge clk);
    test_reset();
    test_single_read();
    test_contention();
    test_write_be();
    test_alternating();
    test_reset_midread();
    test_random();
`ifdef PROGMEM_ARB_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/progmem_avalon_arbiter.md
Name: progmem_avalon_arbiter

Overview:
- Two-master Avalon-MM arbiter in front of the 32K x 32 single-port on-chip program/data RAM (altsyncram, 15-bit word address, 4 byte enables, unregistered output, 1-cycle read latency).
- Shares the RAM between the Nios II data master (m0) and the ChaCha20 key/nonce/block fetch engine (m1).
- Uses bounded round-robin arbitration and routes pipelined read data back to the correct owner.

Parameters:
- ADDR_W, 15, word address width of RAM and both masters
- DATA_W, 32, data width; byteenable width is DATA_W/8
- MAX_HOLD, 4, max consecutive accepted transfers by one master while the other waits (1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_address  in  ADDR_W  master 0 word address
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_byteenable  in  DATA_W/8  master 0 byte lanes
- m0_writedata  in  DATA_W  master 0 write data
- m0_waitrequest  out  1  master 0 request not accepted this cycle
- m0_readdata  out  DATA_W  read data (broadcast)
- m0_readdatavalid  out  1  read data valid for master 0
- m1_*  same set as m0_*, for master 1
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  DATA_W/8  RAM byte enables
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write
- mem_writedata  out  DATA_W  RAM write data
- mem_clken  out  1  RAM clock enable
- mem_readdata  in  DATA_W  RAM read data, valid 1 cycle after read is issued

Behaviour:
- req_x = mx_read | mx_write. Read and write asserted together is illegal: write wins; simulation assertion fires.
- Registered state: owner {IDLE, OWN0, OWN1}, hold_cnt (4 b), last_served (1 b), rd_pend (1 b), rd_owner (1 b).
- Combinational grant, evaluated each cycle:
  - Only one req → that master.
  - Both, state IDLE → master != last_served.
  - Both, owner x, hold_cnt < MAX_HOLD → x.
  - Otherwise → the other master.
- mx_waitrequest = req_x & ~grant_x. It is 0 when not requesting and forced 1 while reset is high.
- Accept = req & grant. A transfer is accepted the same cycle it is granted; zero added latency.
- RAM side: mem_* = granted master's signals, mem_chipselect = any accept, mem_write = accepted write. mem_clken = 1.
- On accept by x:
  - owner == x → hold_cnt++ (saturate at 15).
  - owner != x → owner <= OWNx, hold_cnt <= 1.
  - last_served <= x in both cases.
- No request → owner <= IDLE, hold_cnt <= 0; last_served kept.
- Read return:
  - Accepted read sets rd_pend = 1, rd_owner = x for the next cycle.
  - In that cycle mx_readdatavalid = rd_pend & (rd_owner == x); readdata = mem_readdata to both masters.
  - Back-to-back reads, including alternating masters, give one valid per cycle in order.
  - Writes produce no readdatavalid.
- Reset values: owner IDLE, hold_cnt 0, last_served 1 (m0 wins the first tie), rd_pend 0, all readdatavalid 0, mem_chipselect/mem_write 0.
- Reset mid-read discards the in-flight read; no readdatavalid after reset release.

Optional Feature:
- Macro PROGMEM_ARB_PERF_EN.
- Defined: adds outputs perf_acc0, perf_acc1 (32 b, accepted transfers per master) and perf_stall0, perf_stall1 (32 b, cycles with mx_waitrequest = 1).
  - Counters wrap at 2^32 and clear on reset.
  - Input perf_clear (1 b, synchronous) zeroes all four; clear wins over a simultaneous increment.
- Undefined: ports and counters absent; arbitration identical.

Decomposition:
- Package progmem_arb_pkg holds:
  - owner_e enum (IDLE, OWN0, OWN1)
  - ADDR_W/DATA_W defaults
  - MAX_HOLD default
  - HOLD_CNT_W = 4
- One natural sub-module, progmem_arb_perf, holds the four counters. It is instantiated only under PROGMEM_ARB_PERF_EN.

Test Plan:
- m0 read addr 0x0010 alone, RAM word = 0xDEADBEEF → m0_waitrequest 0, m0_readdatavalid high next cycle with 0xDEADBEEF; m1_readdatavalid stays 0.
- m0 and m1 both read continuously from reset, MAX_HOLD = 4 → grant order m0 x4, m1 x4, m0 x4; readdatavalid owner sequence matches, one per cycle.
- m1 write 0xA5A5A5A5, byteenable 0b0011 to 0x7FFF while m0 idle, then m1 read 0x7FFF → readdata 0xXXXXA5A5 (upper bytes unchanged).
- Single-cycle alternating requests, m0 at cycle n, m1 at n+1 → both accepted with zero wait; readdatavalid at n+1 (m0) and n+2 (m1).
- Reset asserted the cycle after an accepted m1 read → no m1_readdatavalid; after release both idle, and a simultaneous request grants m0 first.
- PROGMEM_ARB_PERF_EN: 10 contended cycles at MAX_HOLD = 4 → perf_acc0 + perf_acc1 = 10, perf_stall totals = 10; perf_clear → all 0 next cycle.
